// File: rtl/game_master_pkg.sv
// Shared types and sizing helpers for the parametrised game master FSM.
// Optional build macro used by the top: GAME_MASTER_TIMER_EN.
package game_master_pkg;

  typedef enum logic [2:0] {
    ST_START_GAME  = 3'd0,
    ST_START_ROUND = 3'd1,
    ST_AIM         = 3'd2,
    ST_SHOOT       = 3'd3,
    ST_END_ROUND   = 3'd4,
    ST_GAME_OVER   = 3'd5
  } state_t;

  localparam int N_TARGETS_DEF = 3;
  localparam int N_LIVES_DEF   = 3;
  localparam int WIN_SCORE_DEF = 3;

  function automatic int sw_f(input int win_score);
    return $clog2(win_score + 1);
  endfunction

  function automatic int lw_f(input int n_lives);
    return $clog2(n_lives + 1);
  endfunction

  function automatic int cw_f(input int n_targets);
    return $clog2(n_targets + 1);
  endfunction

endpackage

// File: rtl/game_master_popcount.sv
// Combinational population count of the per-cycle new-hit vector.
module game_master_popcount
  import game_master_pkg::*;
#(
  parameter int N_TARGETS = N_TARGETS_DEF
) (
  input  logic [N_TARGETS-1:0]          vec,
  output logic [cw_f(N_TARGETS)-1:0]    count
);

  localparam int CW = cw_f(N_TARGETS);

  always_comb begin
    count = '0;
    for (int i = 0; i < N_TARGETS; i++) begin
      count = count + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/game_master_fsm_param.sv
// Parametrised game master FSM: round sequencing, sprite strobes, score and lives.
// Build macro GAME_MASTER_TIMER_EN: timer expiry in AIM/SHOOT forces a lost game.
module game_master_fsm_param
  import game_master_pkg::*;
#(
  parameter int N_TARGETS = N_TARGETS_DEF,
  parameter int N_LIVES   = N_LIVES_DEF,
  parameter int WIN_SCORE = WIN_SCORE_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         launch_key,
  input  logic [N_TARGETS-1:0]         target_within_screen,
  input  logic                         bullet_within_screen,
  input  logic                         spaceship_within_screen,
  input  logic                         collision,
  input  logic [N_TARGETS-1:0]         collision_bullet,
  input  logic                         end_of_game_timer_running,
  output logic [N_TARGETS-1:0]         target_write_xy,
  output logic [N_TARGETS-1:0]         target_write_dxy,
  output logic [N_TARGETS-1:0]         target_enable_update,
  output logic [N_TARGETS-1:0]         target_rgb_en,
  output logic                         bullet_write_xy,
  output logic                         bullet_write_dxy,
  output logic                         bullet_enable_update,
  output logic                         spaceship_write_xy,
  output logic                         spaceship_write_dxy,
  output logic                         spaceship_enable_update,
  output logic [N_LIVES-1:0]           heart_write_xy,
  output logic [N_LIVES-1:0]           heart_rgb_en,
  output logic                         end_of_game_timer_start,
  output logic                         game_over,
  output logic                         game_won,
  output logic [sw_f(WIN_SCORE)-1:0]   score,
  output logic [lw_f(N_LIVES)-1:0]     n_lives,
  output logic [2:0]                   state_dbg
);

  localparam int SW = sw_f(WIN_SCORE);
  localparam int LW = lw_f(N_LIVES);
  localparam int CW = cw_f(N_TARGETS);

  state_t                 state, state_n;
  logic [N_TARGETS-1:0]   hit_mask, hit_mask_n, new_hits, unhit_off;
  logic [CW-1:0]          new_cnt;
  logic [SW+CW-1:0]       score_sum;
  logic [SW-1:0]          score_n;
  logic [LW-1:0]          lives_n;
  logic                   won_n;
  logic                   key_prev;
  logic                   timer_expired;

  logic [N_TARGETS-1:0]   t_wxy_n, t_wdxy_n, t_en_n;
  logic                   b_wxy_n, b_wdxy_n, b_en_n;
  logic                   s_wxy_n, s_wdxy_n, s_en_n;
  logic [N_LIVES-1:0]     h_wxy_n, h_rgb_n;
  logic                   timer_start_n;

  function automatic logic [SW-1:0] sat_score(input logic [SW+CW-1:0] s);
    if (s >= (SW+CW)'(WIN_SCORE)) return SW'(WIN_SCORE);
    return s[SW-1:0];
  endfunction

  function automatic logic [LW-1:0] lose_life(input logic [LW-1:0] l);
    if (l == '0) return l;
    return l - LW'(1);
  endfunction

`ifdef GAME_MASTER_TIMER_EN
  assign timer_expired = ~end_of_game_timer_running;
`else
  logic unused_timer_running;
  assign unused_timer_running = end_of_game_timer_running;
  assign timer_expired        = 1'b0;
`endif

  assign new_hits  = collision_bullet & ~hit_mask;
  assign unhit_off = ~hit_mask & ~target_within_screen;
  assign score_sum = (SW+CW)'(score) + (SW+CW)'(new_cnt);
  assign state_dbg = state;

  game_master_popcount #(
    .N_TARGETS (N_TARGETS)
  ) u_popcount (
    .vec   (new_hits),
    .count (new_cnt)
  );

  always_comb begin
    state_n       = state;
    hit_mask_n    = hit_mask;
    score_n       = score;
    lives_n       = n_lives;
    won_n         = game_won;
    t_wxy_n       = '0;
    t_wdxy_n      = '0;
    t_en_n        = '0;
    b_wxy_n       = 1'b0;
    b_wdxy_n      = 1'b0;
    b_en_n        = 1'b0;
    s_wxy_n       = 1'b0;
    s_wdxy_n      = 1'b0;
    s_en_n        = 1'b0;
    h_wxy_n       = '0;
    timer_start_n = 1'b0;

    case (state)
      ST_START_GAME: begin
        score_n       = '0;
        lives_n       = LW'(N_LIVES);
        won_n         = 1'b0;
        timer_start_n = 1'b1;
        h_wxy_n       = '1;
        hit_mask_n    = '0;
        state_n       = ST_START_ROUND;
      end
      ST_START_ROUND: begin
        t_wxy_n    = '1;
        t_wdxy_n   = '1;
        s_wxy_n    = 1'b1;
        b_wxy_n    = 1'b1;
        hit_mask_n = '0;
        state_n    = ST_AIM;
      end
      ST_AIM: begin
        if (timer_expired) begin
          won_n   = 1'b0;
          state_n = ST_GAME_OVER;
        end else if (collision) begin
          lives_n = lose_life(n_lives);
          state_n = ST_END_ROUND;
        end else if (launch_key) begin
          state_n = ST_SHOOT;
        end else if (|unhit_off) begin
          state_n = ST_END_ROUND;
        end
        t_en_n = ~hit_mask_n;
      end
      ST_SHOOT: begin
        s_wdxy_n = 1'b1;
        b_wdxy_n = 1'b1;
        b_en_n   = 1'b1;
        s_en_n   = 1'b1;
        // A spaceship collision voids any bullet hits landing in the same cycle.
        if (timer_expired) begin
          won_n   = 1'b0;
          state_n = ST_GAME_OVER;
        end else if (collision) begin
          lives_n = lose_life(n_lives);
          state_n = ST_END_ROUND;
        end else if (|new_hits) begin
          score_n    = sat_score(score_sum);
          hit_mask_n = hit_mask | new_hits;
        end else if ((&hit_mask) || !bullet_within_screen ||
                     !spaceship_within_screen || (|unhit_off)) begin
          state_n = ST_END_ROUND;
        end
        t_en_n = ~hit_mask_n;
      end
      ST_END_ROUND: begin
        if (score == SW'(WIN_SCORE)) begin
          won_n   = 1'b1;
          state_n = ST_GAME_OVER;
        end else if (n_lives == '0) begin
          state_n = ST_GAME_OVER;
        end else begin
          state_n = ST_START_ROUND;
        end
      end
      ST_GAME_OVER: begin
        // Only a fresh press restarts; a key still held from SHOOT is ignored.
        if (launch_key && !key_prev) state_n = ST_START_GAME;
      end
      default: state_n = ST_START_GAME;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N_LIVES; i++) begin
      h_rgb_n[i] = (int'(lives_n) > i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                   <= ST_START_GAME;
      hit_mask                <= '0;
      key_prev                <= 1'b0;
      score                   <= '0;
      n_lives                 <= LW'(N_LIVES);
      game_won                <= 1'b0;
      game_over               <= 1'b0;
      target_write_xy         <= '0;
      target_write_dxy        <= '0;
      target_enable_update    <= '0;
      target_rgb_en           <= '0;
      bullet_write_xy         <= 1'b0;
      bullet_write_dxy        <= 1'b0;
      bullet_enable_update    <= 1'b0;
      spaceship_write_xy      <= 1'b0;
      spaceship_write_dxy     <= 1'b0;
      spaceship_enable_update <= 1'b0;
      heart_write_xy          <= '0;
      heart_rgb_en            <= '0;
      end_of_game_timer_start <= 1'b0;
    end else begin
      state                   <= state_n;
      hit_mask                <= hit_mask_n;
      key_prev                <= launch_key;
      score                   <= score_n;
      n_lives                 <= lives_n;
      game_won                <= won_n;
      game_over               <= (state_n == ST_GAME_OVER);
      target_write_xy         <= t_wxy_n;
      target_write_dxy        <= t_wdxy_n;
      target_enable_update    <= t_en_n;
      target_rgb_en           <= ~hit_mask_n;
      bullet_write_xy         <= b_wxy_n;
      bullet_write_dxy        <= b_wdxy_n;
      bullet_enable_update    <= b_en_n;
      spaceship_write_xy      <= s_wxy_n;
      spaceship_write_dxy     <= s_wdxy_n;
      spaceship_enable_update <= s_en_n;
      heart_write_xy          <= h_wxy_n;
      heart_rgb_en            <= h_rgb_n;
      end_of_game_timer_start <= timer_start_n;
    end
  end

endmodule

// File: tb/tb_game_master_fsm_param.sv
// Bench for game_master_fsm_param: directed scenarios plus randomized play against a behavioural model.
module tb_game_master_fsm_param;

  localparam int NT   = 3;
  localparam int NL   = 3;
  localparam int WS   = 3;
  localparam int ALL  = (1 << NT) - 1;
  localparam int HALL = (1 << NL) - 1;

  logic clk = 1'b0;
  logic rst_n;
  logic launch_key;
  logic [NT-1:0] target_within_screen;
  logic bullet_within_screen, spaceship_within_screen, collision;
  logic [NT-1:0] collision_bullet;
  logic end_of_game_timer_running;
  logic [NT-1:0] target_write_xy, target_write_dxy, target_enable_update, target_rgb_en;
  logic bullet_write_xy, bullet_write_dxy, bullet_enable_update;
  logic spaceship_write_xy, spaceship_write_dxy, spaceship_enable_update;
  logic [NL-1:0] heart_write_xy, heart_rgb_en;
  logic end_of_game_timer_start, game_over, game_won;
  logic [1:0] score, n_lives;
  logic [2:0] state_dbg;

  game_master_fsm_param #(.N_TARGETS(NT), .N_LIVES(NL), .WIN_SCORE(WS)) dut (
    .clk(clk), .rst_n(rst_n), .launch_key(launch_key),
    .target_within_screen(target_within_screen),
    .bullet_within_screen(bullet_within_screen),
    .spaceship_within_screen(spaceship_within_screen),
    .collision(collision), .collision_bullet(collision_bullet),
    .end_of_game_timer_running(end_of_game_timer_running),
    .target_write_xy(target_write_xy), .target_write_dxy(target_write_dxy),
    .target_enable_update(target_enable_update), .target_rgb_en(target_rgb_en),
    .bullet_write_xy(bullet_write_xy), .bullet_write_dxy(bullet_write_dxy),
    .bullet_enable_update(bullet_enable_update),
    .spaceship_write_xy(spaceship_write_xy), .spaceship_write_dxy(spaceship_write_dxy),
    .spaceship_enable_update(spaceship_enable_update),
    .heart_write_xy(heart_write_xy), .heart_rgb_en(heart_rgb_en),
    .end_of_game_timer_start(end_of_game_timer_start),
    .game_over(game_over), .game_won(game_won),
    .score(score), .n_lives(n_lives), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Model: game phase, score, lives, hit set, win flag, last key level.
  int m_phase, m_score, m_lives, m_mask, m_won, m_prev;
  int e_txy, e_tdxy, e_ten, e_trgb, e_bxy, e_bdxy, e_ben, e_sxy, e_sdxy, e_sen;
  int e_hxy, e_hrgb, e_tstart, e_over;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_score = 0; m_lives = NL; m_mask = 0; m_won = 0; m_prev = 0;
    e_txy = 0; e_tdxy = 0; e_ten = 0; e_trgb = 0; e_bxy = 0; e_bdxy = 0; e_ben = 0;
    e_sxy = 0; e_sdxy = 0; e_sen = 0; e_hxy = 0; e_hrgb = 0; e_tstart = 0; e_over = 0;
  endtask

  function automatic bit timer_out();
`ifdef GAME_MASTER_TIMER_EN
    return !end_of_game_timer_running;
`else
    return 1'b0;
`endif
  endfunction

  // One clock of game rules, evaluated on the inputs present at the edge.
  task automatic model_step();
    int nxt, newh, cb, offs;
    cb   = int'(collision_bullet);
    newh = cb & ~m_mask & ALL;
    offs = ~int'(target_within_screen) & ~m_mask & ALL;
    nxt  = m_phase;
    e_txy = 0; e_tdxy = 0; e_ten = 0; e_bxy = 0; e_bdxy = 0; e_ben = 0;
    e_sxy = 0; e_sdxy = 0; e_sen = 0; e_hxy = 0; e_tstart = 0;
    if (m_phase == 0) begin
      m_score = 0; m_lives = NL; m_won = 0; m_mask = 0;
      e_tstart = 1; e_hxy = HALL; nxt = 1;
    end else if (m_phase == 1) begin
      e_txy = ALL; e_tdxy = ALL; e_sxy = 1; e_bxy = 1; m_mask = 0; nxt = 2;
    end else if (m_phase == 2 || m_phase == 3) begin
      if (m_phase == 3) begin
        e_sdxy = 1; e_bdxy = 1; e_ben = 1; e_sen = 1;
      end
      if (timer_out()) begin
        m_won = 0; nxt = 5;
      end else if (collision) begin
        m_lives = (m_lives > 0) ? m_lives - 1 : 0; nxt = 4;
      end else if (m_phase == 2) begin
        if (launch_key) nxt = 3;
        else if (offs != 0) nxt = 4;
      end else if (newh != 0) begin
        m_score = m_score + $countones(newh);
        if (m_score > WS) m_score = WS;
        m_mask = m_mask | newh;
      end else if (m_mask == ALL || !bullet_within_screen ||
                   !spaceship_within_screen || offs != 0) begin
        nxt = 4;
      end
      e_ten = ~m_mask & ALL;
    end else if (m_phase == 4) begin
      if (m_score == WS) begin m_won = 1; nxt = 5; end
      else if (m_lives == 0) nxt = 5;
      else nxt = 1;
    end else if (m_phase == 5) begin
      if (launch_key && !m_prev) nxt = 0;
    end else begin
      nxt = 0;
    end
    m_prev  = int'(launch_key);
    m_phase = nxt;
    e_trgb  = ~m_mask & ALL;
    e_hrgb  = (1 << m_lives) - 1;
    e_over  = (nxt == 5);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("state_dbg", int'(state_dbg), m_phase);
      cmp("score", int'(score), m_score);
      cmp("n_lives", int'(n_lives), m_lives);
      cmp("game_won", int'(game_won), m_won);
      cmp("game_over", int'(game_over), e_over);
      cmp("target_write_xy", int'(target_write_xy), e_txy);
      cmp("target_write_dxy", int'(target_write_dxy), e_tdxy);
      cmp("target_enable_update", int'(target_enable_update), e_ten);
      cmp("target_rgb_en", int'(target_rgb_en), e_trgb);
      cmp("bullet_write_xy", int'(bullet_write_xy), e_bxy);
      cmp("bullet_write_dxy", int'(bullet_write_dxy), e_bdxy);
      cmp("bullet_enable_update", int'(bullet_enable_update), e_ben);
      cmp("spaceship_write_xy", int'(spaceship_write_xy), e_sxy);
      cmp("spaceship_write_dxy", int'(spaceship_write_dxy), e_sdxy);
      cmp("spaceship_enable_update", int'(spaceship_enable_update), e_sen);
      cmp("heart_write_xy", int'(heart_write_xy), e_hxy);
      cmp("heart_rgb_en", int'(heart_rgb_en), e_hrgb);
      cmp("timer_start", int'(end_of_game_timer_start), e_tstart);
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    else model_reset();
    #1;
  endtask

  task automatic quiet();
    launch_key = 0; collision = 0; collision_bullet = '0;
    target_within_screen = '1; bullet_within_screen = 1; spaceship_within_screen = 1;
    end_of_game_timer_running = 1;
  endtask

  initial begin
    rst_n = 0;
    quiet();
    model_reset();
    chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_state", int'(state_dbg), 0);
    cmp("rst_n_lives", int'(n_lives), 3);
    cmp("rst_heart_rgb", int'(heart_rgb_en), 0);
    #1 rst_n = 1;

    // Start-up sequence
    tick();
    cmp("start_timer_pulse", int'(end_of_game_timer_start), 1);
    cmp("start_heart_xy", int'(heart_write_xy), 3'b111);
    tick();
    cmp("round_target_xy", int'(target_write_xy), 3'b111);
    cmp("reach_aim", int'(state_dbg), 2);

    // Fire, then a double hit
    launch_key = 1; tick();
    cmp("enter_shoot", int'(state_dbg), 3);
    launch_key = 0; collision_bullet = 3'b011; tick();
    cmp("double_hit_score", int'(score), 2);
    cmp("double_hit_rgb", int'(target_rgb_en), 3'b100);
    cmp("double_hit_en", int'(target_enable_update), 3'b100);
    cmp("stay_shoot", int'(state_dbg), 3);

    // Collision wins over a same-cycle bullet hit
    collision = 1; collision_bullet = 3'b100; tick();
    cmp("coll_lives", int'(n_lives), 2);
    cmp("coll_score", int'(score), 2);
    cmp("coll_hearts", int'(heart_rgb_en), 3'b011);
    collision = 0; collision_bullet = '0;
    tick(); tick();
    collision = 1; tick();
    cmp("lives_1", int'(n_lives), 1);
    cmp("hearts_1", int'(heart_rgb_en), 3'b001);
    collision = 0; tick(); tick();
    collision = 1; tick();
    cmp("lives_0", int'(n_lives), 0);
    cmp("hearts_0", int'(heart_rgb_en), 3'b000);
    collision = 0; launch_key = 1; tick();
    cmp("lost_over", int'(game_over), 1);
    cmp("lost_won", int'(game_won), 0);

    // Held key must not restart; a fresh press does
    repeat (3) tick();
    cmp("held_no_restart", int'(state_dbg), 5);
    launch_key = 0; tick();
    launch_key = 1; tick();
    cmp("restart_state", int'(state_dbg), 0);
    launch_key = 0; tick();
    cmp("restart_score", int'(score), 0);
    cmp("restart_lives", int'(n_lives), 3);
    tick();

    // Timer expiry in AIM
    end_of_game_timer_running = 0; tick();
`ifdef GAME_MASTER_TIMER_EN
    cmp("timer_over", int'(state_dbg), 5);
`else
    cmp("timer_ignored", int'(state_dbg), 2);
`endif
    cmp("timer_won", int'(game_won), 0);
    end_of_game_timer_running = 1;

    // Randomized play
    for (int n = 0; n < 4000; n++) begin
      launch_key = ($urandom_range(0, 3) == 0);
      collision = ($urandom_range(0, 15) == 0);
      collision_bullet = ($urandom_range(0, 2) == 0) ? NT'($urandom) : '0;
      target_within_screen = ($urandom_range(0, 15) == 0) ? NT'($urandom) : '1;
      bullet_within_screen = ($urandom_range(0, 19) != 0);
      spaceship_within_screen = ($urandom_range(0, 19) != 0);
      end_of_game_timer_running = ($urandom_range(0, 49) != 0);
      if (n == 2000) begin
        rst_n = 0;
        model_reset();
      end
      if (n == 2002) rst_n = 1;
      tick();
    end

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
